// File: rtl/alu_issue_queue.sv
// ALU issue queue: compacting, oldest-ready-first select with CDB wakeup,
// feeding a registered issue stage that drives the ALU operand interface.
package nand_cpu_pkg;
  typedef enum logic [2:0] {
    ALU_CL,
    ALU_CP,
    ALU_LI,
    ALU_NAND,
    ALU_ADD,
    ALU_SUB,
    ALU_SHL,
    ALU_SHR
  } AluOp;
endpackage

interface alu_input_ifc;
  import nand_cpu_pkg::*;
  logic [15:0] op0;
  logic [15:0] op1;
  AluOp        alu_op;
  modport out  (output op0, output op1, output alu_op);
  modport sink (input op0, input op1, input alu_op);
endinterface

// Handshakes: rename -> queue transfers when in_valid && in_ready at a clock
// edge; the staged instruction leaves when issue_valid && issue_ready at a
// clock edge. Neither valid may depend combinationally on its ready.
module alu_issue_queue
  import nand_cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  AluOp                         in_alu_op,
  input  logic [TAG_W-1:0]             in_dest_tag,
  input  logic [TAG_W-1:0]             in_src0_tag,
  input  logic [TAG_W-1:0]             in_src1_tag,
  input  logic                         in_src0_rdy,
  input  logic                         in_src1_rdy,
  input  logic [15:0]                  in_src0_val,
  input  logic [15:0]                  in_src1_val,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [15:0]                  cdb_val,
  alu_input_ifc.out                    alu,
  output logic                         issue_valid,
  output logic [TAG_W-1:0]             issue_dest_tag,
  input  logic                         issue_ready,
  output logic [$clog2(DEPTH+1)-1:0]   dbg_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    AluOp             op;
    logic [TAG_W-1:0] dest;
    logic [TAG_W-1:0] s0_tag;
    logic             s0_rdy;
    logic [15:0]      s0_val;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_rdy;
    logic [15:0]      s1_val;
  } entry_t;

  entry_t           q_q   [DEPTH];
  entry_t           q_d   [DEPTH];
  entry_t           woke  [DEPTH+1];
  entry_t           new_e;
  logic [CNT_W-1:0] count_q, count_d, cnt_after;

  logic             issue_valid_q;
  logic [15:0]      op0_q, op1_q;
  AluOp             alu_op_q;
  logic [TAG_W-1:0] dest_q;

  logic             stage_free, sel_found, do_issue, accept;
  logic [IDX_W-1:0] sel_idx;

  // Capture a broadcast into any still-waiting source of a live entry.
  function automatic entry_t wake(input entry_t e, input logic v,
                                  input logic [TAG_W-1:0] t, input logic [15:0] val);
    entry_t r;
    r = e;
    if (v && e.valid) begin
      if (!e.s0_rdy && e.s0_tag == t) begin
        r.s0_rdy = 1'b1;
        r.s0_val = val;
      end
      if (!e.s1_rdy && e.s1_tag == t) begin
        r.s1_rdy = 1'b1;
        r.s1_val = val;
      end
    end
    return r;
  endfunction

  assign in_ready = (count_q < CNT_W'(DEPTH));

  always_comb begin
    stage_free = !issue_valid_q || issue_ready;
    accept     = in_valid && in_ready && !flush;

    // Select uses registered readiness only, so a same-cycle wakeup waits a cycle.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q_q[i].valid && q_q[i].s0_rdy && q_q[i].s1_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    do_issue = stage_free && sel_found;

    woke[DEPTH] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = wake(q_q[i], cdb_valid, cdb_tag, cdb_val);
    end

    new_e        = '0;
    new_e.valid  = 1'b1;
    new_e.op     = in_alu_op;
    new_e.dest   = in_dest_tag;
    new_e.s0_tag = in_src0_tag;
    new_e.s0_rdy = in_src0_rdy;
    new_e.s0_val = in_src0_val;
    new_e.s1_tag = in_src1_tag;
    new_e.s1_rdy = in_src1_rdy;
    new_e.s1_val = in_src1_val;
    new_e        = wake(new_e, cdb_valid, cdb_tag, cdb_val);

    cnt_after = count_q - CNT_W'(do_issue);
    for (int i = 0; i < DEPTH; i++) begin
      if (do_issue && i >= int'(sel_idx)) q_d[i] = woke[i+1];
      else                                q_d[i] = woke[i];
      if (accept && cnt_after == CNT_W'(i)) q_d[i] = new_e;
    end
    count_d = cnt_after + CNT_W'(accept);

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) q_d[i] = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) q_q[i] <= '0;
    end else begin
      count_q <= count_d;
      q_q     <= q_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid_q <= 1'b0;
      op0_q         <= '0;
      op1_q         <= '0;
      alu_op_q      <= ALU_CL;
      dest_q        <= '0;
    end else if (flush) begin
      issue_valid_q <= 1'b0;
    end else if (stage_free) begin
      issue_valid_q <= sel_found;
      if (sel_found) begin
        op0_q    <= q_q[sel_idx].s0_val;
        op1_q    <= q_q[sel_idx].s1_val;
        alu_op_q <= q_q[sel_idx].op;
        dest_q   <= q_q[sel_idx].dest;
      end
    end
  end

  assign alu.op0        = op0_q;
  assign alu.op1        = op1_q;
  assign alu.alu_op     = alu_op_q;
  assign issue_valid    = issue_valid_q;
  assign issue_dest_tag = dest_q;
  assign dbg_count      = count_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: inline checks plus an in-order
// scoreboard of expected issued instructions.
module tb_alu_issue_queue;
  import nand_cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int W     = TAG_W + 3 + 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  AluOp             in_alu_op = ALU_CL;
  logic [TAG_W-1:0] in_dest_tag = '0, in_src0_tag = '0, in_src1_tag = '0;
  logic             in_src0_rdy = 1'b0, in_src1_rdy = 1'b0;
  logic [15:0]      in_src0_val = '0, in_src1_val = '0;
  logic             cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [15:0]      cdb_val = '0;
  logic             issue_valid;
  logic [TAG_W-1:0] issue_dest_tag;
  logic             issue_ready = 1'b1;
  logic [2:0]       dbg_count;

  alu_input_ifc alu_if ();

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_dest_tag(in_dest_tag), .in_src0_tag(in_src0_tag), .in_src1_tag(in_src1_tag),
    .in_src0_rdy(in_src0_rdy), .in_src1_rdy(in_src1_rdy),
    .in_src0_val(in_src0_val), .in_src1_val(in_src1_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .alu(alu_if), .issue_valid(issue_valid), .issue_dest_tag(issue_dest_tag),
    .issue_ready(issue_ready), .dbg_count(dbg_count)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_got;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [TAG_W-1:0] dest, input AluOp op,
                                        input logic [15:0] a, input logic [15:0] b);
    return {dest, op, a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input AluOp op, input logic [TAG_W-1:0] dest,
                       input logic [TAG_W-1:0] s0t, input logic s0r, input logic [15:0] s0v,
                       input logic [TAG_W-1:0] s1t, input logic s1r, input logic [15:0] s1v);
    in_valid    = 1'b1;
    in_alu_op   = op;
    in_dest_tag = dest;
    in_src0_tag = s0t;
    in_src0_rdy = s0r;
    in_src0_val = s0v;
    in_src1_tag = s1t;
    in_src1_rdy = s1r;
    in_src1_val = s1v;
  endtask

  task automatic bcast(input logic v, input logic [TAG_W-1:0] t, input logic [15:0] val);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_val   = val;
  endtask

  task automatic check_stage(input string tag, input logic v, input logic [TAG_W-1:0] dest,
                             input logic [2:0] cnt);
    check({tag, "_valid"}, 64'(issue_valid), 64'(v));
    if (v) check({tag, "_dest"}, 64'(issue_dest_tag), 64'(dest));
    check({tag, "_count"}, 64'(dbg_count), 64'(cnt));
  endtask

  // Every instruction consumed downstream must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && issue_valid && issue_ready) begin
      mon_got = {issue_dest_tag, alu_if.alu_op, alu_if.op0, alu_if.op1};
      check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("sb_issue", 64'(mon_got), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    // Asynchronous reset: values must appear with no clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_issue_valid", 64'(issue_valid), 64'(0));
    check("rst_op0", 64'(alu_if.op0), 64'(0));
    check("rst_op1", 64'(alu_if.op1), 64'(0));
    check("rst_alu_op", 64'(alu_if.alu_op), 64'(ALU_CL));
    check("rst_dest", 64'(issue_dest_tag), 64'(0));
    check("rst_count", 64'(dbg_count), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Basic NAND: one idle cycle in the queue, then staged.
    drive(ALU_NAND, 4'd1, 4'd0, 1'b1, 16'h00FF, 4'd0, 1'b1, 16'h0F0F);
    exp_q.push_back(pack(4'd1, ALU_NAND, 16'h00FF, 16'h0F0F));
    tick();
    in_valid = 1'b0;
    check_stage("nand_acc", 1'b0, 4'd0, 3'd1);
    tick();
    check_stage("nand_iss", 1'b1, 4'd1, 3'd0);
    check("nand_op0", 64'(alu_if.op0), 64'(16'h00FF));
    check("nand_op1", 64'(alu_if.op1), 64'(16'h0F0F));
    check("nand_alu_op", 64'(alu_if.alu_op), 64'(ALU_NAND));
    tick();
    check_stage("nand_drain", 1'b0, 4'd0, 3'd0);

    // Out-of-order: younger ready B overtakes older A waiting on tag 3.
    drive(ALU_ADD, 4'd2, 4'd3, 1'b0, 16'hDEAD, 4'd0, 1'b1, 16'h0001);
    tick();
    drive(ALU_SUB, 4'd4, 4'd0, 1'b1, 16'h1111, 4'd0, 1'b1, 16'h2222);
    exp_q.push_back(pack(4'd4, ALU_SUB, 16'h1111, 16'h2222));
    tick();
    in_valid = 1'b0;
    check_stage("ooo_acc", 1'b0, 4'd0, 3'd2);
    tick();
    check_stage("ooo_b", 1'b1, 4'd4, 3'd1);
    bcast(1'b1, 4'd3, 16'h1234);
    exp_q.push_back(pack(4'd2, ALU_ADD, 16'h1234, 16'h0001));
    tick();
    bcast(1'b0, 4'd0, 16'h0);
    check_stage("ooo_wake", 1'b0, 4'd0, 3'd1);
    tick();
    check_stage("ooo_a", 1'b1, 4'd2, 3'd0);
    check("ooo_a_op0", 64'(alu_if.op0), 64'(16'h1234));

    // Wakeup on the accept cycle overrides the incoming value.
    drive(ALU_ADD, 4'd6, 4'd0, 1'b1, 16'h0005, 4'd5, 1'b0, 16'hDEAD);
    bcast(1'b1, 4'd5, 16'hBEEF);
    exp_q.push_back(pack(4'd6, ALU_ADD, 16'h0005, 16'hBEEF));
    tick();
    in_valid = 1'b0;
    bcast(1'b0, 4'd0, 16'h0);
    check_stage("byp_acc", 1'b0, 4'd0, 3'd1);
    tick();
    check_stage("byp_iss", 1'b1, 4'd6, 3'd0);
    check("byp_op1", 64'(alu_if.op1), 64'(16'hBEEF));

    // Fill with waiting entries, refuse a fifth, wake the third.
    for (int k = 0; k < DEPTH; k++) begin
      drive(ALU_ADD, TAG_W'(7 + k), TAG_W'(8 + k), 1'b0, 16'h0, 4'd0, 1'b1, 16'(k));
      tick();
    end
    check_stage("full", 1'b0, 4'd0, 3'd4);
    check("full_in_ready", 64'(in_ready), 64'(0));
    drive(ALU_ADD, 4'd11, 4'd0, 1'b1, 16'h7777, 4'd0, 1'b1, 16'h7777);
    tick();
    in_valid = 1'b0;
    check("full_refuse_count", 64'(dbg_count), 64'(4));
    bcast(1'b1, 4'd10, 16'hAAAA);
    exp_q.push_back(pack(4'd9, ALU_ADD, 16'hAAAA, 16'h0002));
    tick();
    bcast(1'b0, 4'd0, 16'h0);
    check_stage("full_wake", 1'b0, 4'd0, 3'd4);
    tick();
    check_stage("slot2_iss", 1'b1, 4'd9, 3'd3);
    check("slot2_in_ready", 64'(in_ready), 64'(1));

    // Hold the stage while the remaining three wake; then drain oldest first.
    issue_ready = 1'b0;
    exp_q.push_back(pack(4'd7, ALU_ADD, 16'h8080, 16'h0000));
    exp_q.push_back(pack(4'd8, ALU_ADD, 16'h9090, 16'h0001));
    exp_q.push_back(pack(4'd10, ALU_ADD, 16'hB0B0, 16'h0003));
    bcast(1'b1, 4'd11, 16'hB0B0);
    tick();
    check_stage("hold1", 1'b1, 4'd9, 3'd3);
    bcast(1'b1, 4'd9, 16'h9090);
    tick();
    check_stage("hold2", 1'b1, 4'd9, 3'd3);
    bcast(1'b1, 4'd8, 16'h8080);
    tick();
    check_stage("hold3", 1'b1, 4'd9, 3'd3);
    check("hold_op0", 64'(alu_if.op0), 64'(16'hAAAA));
    bcast(1'b0, 4'd0, 16'h0);
    issue_ready = 1'b1;
    tick();
    check_stage("drain0", 1'b1, 4'd7, 3'd2);
    tick();
    check_stage("drain1", 1'b1, 4'd8, 3'd1);
    tick();
    check_stage("drain3", 1'b1, 4'd10, 3'd0);

    // Flush with a staged instruction, three queued, and an offer pending.
    drive(ALU_NAND, 4'd12, 4'd0, 1'b1, 16'hC0C0, 4'd0, 1'b1, 16'h0C0C);
    exp_q.push_back(pack(4'd12, ALU_NAND, 16'hC0C0, 16'h0C0C));
    tick();
    in_valid = 1'b0;
    issue_ready = 1'b0;
    tick();
    check_stage("fl_staged", 1'b1, 4'd12, 3'd0);
    for (int k = 0; k < 3; k++) begin
      drive(ALU_SUB, TAG_W'(13 + k), TAG_W'(12 + k), 1'b0, 16'h0, 4'd0, 1'b1, 16'h0);
      tick();
    end
    check_stage("fl_pre", 1'b1, 4'd12, 3'd3);
    drive(ALU_ADD, 4'd1, 4'd0, 1'b1, 16'h1, 4'd0, 1'b1, 16'h1);
    bcast(1'b1, 4'd12, 16'h5555);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    bcast(1'b0, 4'd0, 16'h0);
    exp_q.delete();
    check_stage("fl_post", 1'b0, 4'd0, 3'd0);
    issue_ready = 1'b1;
    tick();
    check_stage("fl_after", 1'b0, 4'd0, 3'd0);

    // Reset mid-stream, between clock edges.
    drive(ALU_NAND, 4'd3, 4'd0, 1'b1, 16'h1357, 4'd0, 1'b1, 16'h2468);
    exp_q.push_back(pack(4'd3, ALU_NAND, 16'h1357, 16'h2468));
    tick();
    issue_ready = 1'b0;
    drive(ALU_ADD, 4'd5, 4'd7, 1'b0, 16'h0, 4'd0, 1'b1, 16'h0);
    tick();
    in_valid = 1'b0;
    check_stage("mid_pre", 1'b1, 4'd3, 3'd1);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_issue_valid", 64'(issue_valid), 64'(0));
    check("mid_op0", 64'(alu_if.op0), 64'(0));
    check("mid_op1", 64'(alu_if.op1), 64'(0));
    check("mid_alu_op", 64'(alu_if.alu_op), 64'(ALU_CL));
    check("mid_dest", 64'(issue_dest_tag), 64'(0));
    check("mid_count", 64'(dbg_count), 64'(0));
    check("mid_in_ready", 64'(in_ready), 64'(1));
    tick();
    rst = 1'b0;
    issue_ready = 1'b1;
    tick();
    check_stage("mid_after", 1'b0, 4'd0, 3'd0);

    check("sb_leftover", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
